zorro_irq_ctrl: RTL
===================

Name: zorro_irq_ctrl

Overview:
- Parametrised successor to the single-source INT2 logic on the card.
- Synchronises NUM_SRC interrupt sources and holds pending, mask and mode registers in the interrupt register window.
- Drives the combined Zorro interrupt request.
- Answers Zorro III quick-interrupt cycles with a per-source vector: VECTOR base plus the lowest pending, enabled source index.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8)
DTACK_WAIT, 2, clk cycles from strobe qualification to dtack (0..15)
VEC_RESET, 8'h40, reset value of VECTOR register
AUTO_CLEAR, 1, 1 = quick-interrupt acknowledge clears pending bit of an edge-mode source

Ports:
clk  in  1  50MHz system clock
IORST_n  in  1  asynchronous active-low reset
intreg_cycle  in  1  register window decoded for this card
FCS_n  in  1  Zorro full cycle strobe, low active
DOE  in  1  Zorro data output enable
DS0_n  in  1  byte-lane 0 data strobe, low active
READ  in  1  1 = read, 0 = write
reg_sel  in  2  register select (address bits 3:2)
din  in  8  write data
dout  out  8  read or vector data
data_read  out  1  enables dout onto D[7:0]
dtack  out  1  cycle acknowledge to top-level DTACK logic
quickint_cycle  in  1  qualified ZIII quick-interrupt cycle
slave  out  1  SLAVE request during quick-interrupt response
src_n  in  NUM_SRC  raw interrupt sources, low active, asynchronous
int_sig  out  1  interrupt request to INT2_n driver, 1 = assert

Behaviour:
- Reset (IORST_n low, asynchronous): PEND=0, MASK=0, MODE=0, VECTOR=VEC_RESET, FSM=IDLE; dout=0, data_read=0, dtack=0, slave=0, int_sig=0; synchronisers set to inactive (1).
- src_n passes through a 2-flop synchroniser, then an edge-detect flop.
- Registers, selected by reg_sel. Bits above NUM_SRC read 0 and ignore writes.
  - 0 PEND: read returns pending bits. Writing 1 clears a bit in edge mode only; writes are ignored in level mode.
  - 1 MASK: read/write; 1 = source enabled.
  - 2 MODE: read/write; 1 = edge (falling edge of synchronised source), 0 = level.
  - 3 VECTOR: read/write, 8 bits.
- PEND behaviour:
  - Edge mode: a detected edge sets the bit. Edge set takes priority over a simultaneous W1C or auto-clear.
  - Level mode: the bit equals the synchronised active level each clk.
- int_sig is registered: |(PEND & MASK), one clk after PEND updates.
- Bus FSM states: IDLE, WAIT, ACK, QWAIT, QACK.
  - IDLE→WAIT when intreg_cycle & !FCS_n & DOE & !DS0_n. Load counter with DTACK_WAIT.
  - WAIT: counter decrements each clk. At 0 → ACK. With DTACK_WAIT=0, go straight to ACK on the next clk.
  - Entry to ACK: a write commits exactly once. dtack=1 while in ACK.
  - ACK→IDLE when FCS_n high or intreg_cycle low. dtack drops in the same clk.
  - IDLE→QWAIT when quickint_cycle & int_sig & !FCS_n.
    - slave=1 from entry.
    - Vector latched on entry: VECTOR + index of lowest set bit of PEND&MASK (8-bit wrap).
  - QWAIT→QACK after DTACK_WAIT. QACK: dtack=1.
  - Entry to QACK with AUTO_CLEAR=1: clears the latched source's PEND bit if that source is edge mode.
  - QWAIT/QACK→IDLE on FCS_n high. slave and dtack drop that clk.
  - If int_sig falls during QWAIT, the cycle completes with the latched vector.
  - If register and quick-interrupt qualifiers are both true in IDLE, the quick-interrupt path wins.
- Read data: data_read=1 with READ in WAIT/ACK, and always in QWAIT/QACK.
  - dout is the selected register, or the latched vector in quick-interrupt states.
  - dout and data_read are registered on FSM entry.
- FCS_n rising in any non-IDLE state returns to IDLE with no write committed if ACK was not yet reached.
- Reset asserted mid-cycle: all outputs go to reset values immediately.

Test Plan:
- Reset, then read VECTOR (reg_sel=3, DTACK_WAIT=2) → dout=8'h40, dtack asserted 3 clk after qualification, all other outputs 0.
- Write MASK=4'b0101, MODE=4'b0001, pulse src_n[0] low 1 clk → PEND=4'b0001, int_sig=1. Write PEND=8'h01 → PEND=0, int_sig=0.
- src_n[2] held low in level mode, MASK[2]=1 → int_sig=1; write PEND=8'h04 → no change; release src_n[2] → PEND=0 and int_sig=0 within 4 clk.
- VECTOR=8'hF0, PEND&MASK=4'b0110, quickint_cycle → slave=1, dout=8'hF1, dtack; with source 1 edge mode and AUTO_CLEAR=1, PEND becomes 4'b0100 after QACK.
- Edge on src_n[0] in the same clk as a W1C of bit 0 → PEND[0] stays 1.
- Assert IORST_n low during WAIT of a write to MASK → MASK=0, dtack=0; after release, FSM idles until a new strobe.

Source files
------------

// File: rtl/zorro_irq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : zorro_irq_ctrl
//  Description : Multi-source Zorro interrupt controller. Synchronises NUM_SRC
//                low-active interrupt sources into a pending register and
//                gates them through a mask to drive the combined interrupt
//                request. Serves a four-entry register window:
//                  0 PEND   pending bits, W1C for edge-mode sources
//                  1 MASK   1 = source enabled
//                  2 MODE   1 = falling-edge triggered, 0 = level
//                  3 VECTOR quick-interrupt vector base
//                It also answers Zorro III quick-interrupt cycles with
//                VECTOR + index of the lowest pending, enabled source.
//  Ports       : clk, IORST_n             clock / async active-low reset
//                intreg_cycle, FCS_n, DOE, DS0_n, READ, reg_sel, din
//                                          register window bus inputs
//                quickint_cycle           qualified quick-interrupt cycle
//                dout, data_read          read / vector data and its enable
//                dtack, slave             cycle acknowledge, SLAVE request
//                src_n                    raw sources, low active, async
//                int_sig                  interrupt request, 1 = assert
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module zorro_irq_ctrl #(
   parameter int         NUM_SRC    = 4,
   parameter int         DTACK_WAIT = 2,
   parameter logic [7:0] VEC_RESET  = 8'h40,
   parameter bit         AUTO_CLEAR = 1'b1
) (
   input  logic               clk,
   input  logic               IORST_n,
   input  logic               intreg_cycle,
   input  logic               FCS_n,
   input  logic               DOE,
   input  logic               DS0_n,
   input  logic               READ,
   input  logic [1:0]         reg_sel,
   input  logic [7:0]         din,
   output logic [7:0]         dout,
   output logic               data_read,
   output logic               dtack,
   input  logic               quickint_cycle,
   output logic               slave,
   input  logic [NUM_SRC-1:0] src_n,
   output logic               int_sig
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_WAIT  = 3'd1;
   localparam logic [2:0] c_ACK   = 3'd2;
   localparam logic [2:0] c_QWAIT = 3'd3;
   localparam logic [2:0] c_QACK  = 3'd4;

   localparam logic [3:0] c_WAIT_LOAD = 4'(DTACK_WAIT);

   // Source conditioning
   logic [NUM_SRC-1:0] r_sync1;
   logic [NUM_SRC-1:0] r_sync2;
   logic [NUM_SRC-1:0] r_src_d;
   logic [NUM_SRC-1:0] w_edge;

   // Register file
   logic [NUM_SRC-1:0] r_pend;
   logic [NUM_SRC-1:0] r_mask;
   logic [NUM_SRC-1:0] r_mode;
   logic [7:0]         r_vector;
   logic [NUM_SRC-1:0] w_pend_nxt;
   logic [NUM_SRC-1:0] w_pm;

   // Bus FSM
   logic [2:0] r_state;
   logic [2:0] w_next;
   logic [3:0] r_cnt;
   logic       w_reg_qual;
   logic       w_q_qual;
   logic       w_commit;
   logic       w_aclr;

   // Quick-interrupt selection
   logic [2:0] w_low_idx;
   logic [7:0] w_qvec_new;
   logic [2:0] r_qidx;
   logic [7:0] r_qvec;
   logic [7:0] w_rdata;

   //---------------------------------------------------------------------------
   // Synchroniser and falling-edge detector. All stages reset to the inactive
   // level so that releasing reset never fakes an edge.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge IORST_n) begin
      if (!IORST_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_src_d <= '1;
      end else begin
         r_sync1 <= src_n;
         r_sync2 <= r_sync1;
         r_src_d <= r_sync2;
      end
   end

   assign w_edge = r_src_d & ~r_sync2;
   assign w_pm   = r_pend & r_mask;

   //---------------------------------------------------------------------------
   // Bus FSM next-state. The quick-interrupt qualifier is tested first so it
   // wins when both cycle types appear in the same clock.
   //---------------------------------------------------------------------------
   assign w_reg_qual = intreg_cycle & ~FCS_n & DOE & ~DS0_n;
   assign w_q_qual   = quickint_cycle & int_sig & ~FCS_n;

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_q_qual)        w_next = c_QWAIT;
            else if (w_reg_qual) w_next = c_WAIT;
         end
         c_WAIT: begin
            if (FCS_n)             w_next = c_IDLE;
            else if (r_cnt == 4'd0) w_next = c_ACK;
         end
         c_ACK: begin
            if (FCS_n || !intreg_cycle) w_next = c_IDLE;
         end
         c_QWAIT: begin
            if (FCS_n)             w_next = c_IDLE;
            else if (r_cnt == 4'd0) w_next = c_QACK;
         end
         c_QACK: begin
            if (FCS_n) w_next = c_IDLE;
         end
         default: w_next = c_IDLE;
      endcase
   end

   // A write takes effect only on the WAIT->ACK transition, so it lands once
   // per cycle and is lost if the master aborts before acknowledge.
   assign w_commit = (r_state == c_WAIT) && (w_next == c_ACK) && !READ;
   assign w_aclr   = AUTO_CLEAR && (r_state == c_QWAIT) && (w_next == c_QACK);

   always_ff @(posedge clk or negedge IORST_n) begin
      if (!IORST_n) begin
         r_state <= c_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (r_state == c_IDLE)
            r_cnt <= c_WAIT_LOAD;
         else if ((r_state == c_WAIT || r_state == c_QWAIT) && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
      end
   end

   //---------------------------------------------------------------------------
   // Lowest pending, enabled source and the resulting vector (8-bit wrap).
   //---------------------------------------------------------------------------
   always_comb begin
      w_low_idx = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_pm[i]) w_low_idx = 3'(i);
      end
   end

   assign w_qvec_new = r_vector + {5'd0, w_low_idx};

   // The source index and vector are frozen on entry so the cycle completes
   // consistently even if the request goes away mid-cycle.
   always_ff @(posedge clk or negedge IORST_n) begin
      if (!IORST_n) begin
         r_qidx <= 3'd0;
         r_qvec <= 8'd0;
      end else if (r_state == c_IDLE && w_next == c_QWAIT) begin
         r_qidx <= w_low_idx;
         r_qvec <= w_qvec_new;
      end
   end

   //---------------------------------------------------------------------------
   // Pending bits. Level sources mirror the synchronised level; edge sources
   // set on a falling edge, which outranks a simultaneous W1C or auto-clear.
   //---------------------------------------------------------------------------
   always_comb begin
      w_pend_nxt = r_pend;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!r_mode[i])
            w_pend_nxt[i] = ~r_sync2[i];
         else if (w_edge[i])
            w_pend_nxt[i] = 1'b1;
         else if ((w_commit && reg_sel == 2'd0 && din[i]) ||
                  (w_aclr && r_qidx == 3'(i)))
            w_pend_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge IORST_n) begin
      if (!IORST_n) begin
         r_pend   <= '0;
         r_mask   <= '0;
         r_mode   <= '0;
         r_vector <= VEC_RESET;
         int_sig  <= 1'b0;
      end else begin
         r_pend  <= w_pend_nxt;
         int_sig <= |w_pm;
         if (w_commit) begin
            case (reg_sel)
               2'd1:    r_mask   <= din[NUM_SRC-1:0];
               2'd2:    r_mode   <= din[NUM_SRC-1:0];
               2'd3:    r_vector <= din;
               default: ;
            endcase
         end
      end
   end

   //---------------------------------------------------------------------------
   // Read mux; unimplemented upper bits read as zero.
   //---------------------------------------------------------------------------
   always_comb begin
      w_rdata = 8'd0;
      case (reg_sel)
         2'd0:    w_rdata[NUM_SRC-1:0] = r_pend;
         2'd1:    w_rdata[NUM_SRC-1:0] = r_mask;
         2'd2:    w_rdata[NUM_SRC-1:0] = r_mode;
         default: w_rdata              = r_vector;
      endcase
   end

   //---------------------------------------------------------------------------
   // Registered bus outputs, derived from the state being entered so they
   // change on the same edge as the FSM.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge IORST_n) begin
      if (!IORST_n) begin
         dout      <= 8'd0;
         data_read <= 1'b0;
         dtack     <= 1'b0;
         slave     <= 1'b0;
      end else begin
         dtack <= (w_next == c_ACK) || (w_next == c_QACK);
         slave <= (w_next == c_QWAIT) || (w_next == c_QACK);
         case (w_next)
            c_WAIT, c_ACK: begin
               data_read <= READ;
               dout      <= w_rdata;
            end
            c_QWAIT, c_QACK: begin
               data_read <= 1'b1;
               dout      <= (r_state == c_IDLE) ? w_qvec_new : r_qvec;
            end
            default: begin
               data_read <= 1'b0;
               dout      <= 8'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
